// File: rtl/serial_pkg.sv
// Shared types and elaboration helpers for the serial add/subtract unit.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of RUN steps needed to consume one operand.
  function automatic int calc_steps(input int width, input int bpc);
    return width / bpc;
  endfunction

  // Step counter width; a single-step configuration still needs one bit.
  function automatic int calc_cnt_w(input int width, input int bpc);
    int steps;
    steps = width / bpc;
    if (steps < 2) begin
      return 1;
    end else begin
      return $clog2(steps);
    end
  endfunction

endpackage

// File: rtl/serial_fa_slice.sv
// Combinational ripple full-adder slice handling BITS_PER_CYCLE bits per step.
module serial_fa_slice #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] x,
  input  logic [BITS_PER_CYCLE-1:0] y,
  input  logic                      cin,
  output logic [BITS_PER_CYCLE-1:0] s,
  output logic                      cout,
  output logic                      cmsb_in
);

  // Ripple the carry bit by bit; cmsb_in keeps the carry entering the top bit.
  always_comb begin
    logic c;
    c       = cin;
    s       = '0;
    cmsb_in = cin;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      cmsb_in = c;
      s[i]    = x[i] ^ y[i] ^ c;
      c       = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, BITS_PER_CYCLE bits per clock.
// Define SERIAL_ADDSUB_OVF_EN to add the signed 'overflow' output.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = calc_cnt_w(WIDTH, BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  if ((WIDTH < 2) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          a_sh_q, a_sh_d;
  logic [WIDTH-1:0]          b_sh_q, b_sh_d;
  logic [WIDTH-1:0]          res_sh_q, res_sh_d;
  logic                      cy_q, cy_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          result_q, result_d;
  logic                      carry_q, carry_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [BITS_PER_CYCLE-1:0] slice_s;
  logic                      cout_s;
  logic                      cmsb_s;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic                      ovf_q, ovf_d;
`else
  logic                      unused_cmsb_s;
  assign unused_cmsb_s = cmsb_s;
`endif

  serial_fa_slice #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_slice (
    .x      (a_sh_q[BITS_PER_CYCLE-1:0]),
    .y      (b_sh_q[BITS_PER_CYCLE-1:0]),
    .cin    (cy_q),
    .s      (slice_s),
    .cout   (cout_s),
    .cmsb_in(cmsb_s)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with the mode bit.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          cy_d    = sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_sh_d = (WIDTH'(slice_s) << (WIDTH - BITS_PER_CYCLE)) | (res_sh_q >> BITS_PER_CYCLE);
        a_sh_d   = a_sh_q >> BITS_PER_CYCLE;
        b_sh_d   = b_sh_q >> BITS_PER_CYCLE;
        cy_d     = cout_s;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          result_d = res_sh_d;
          carry_d  = cout_s;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d    = cmsb_s ^ cout_s;
`endif
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d != RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench: two DUT configurations (8x1 and 16x4) against an arithmetic model.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear = 1'b0;
  logic        start8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0, res8;
  logic        ready8, busy8, done8, carry8;
  logic        start16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = 16'd0, b16 = 16'd0, res16;
  logic        ready16, busy16, done16, carry16;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic        ovf8, ovf16;
`endif

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk(clk), .clear(clear), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .result(res8), .carry(carry8)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .overflow(ovf8)
`endif
  );

  serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
    .clk(clk), .clear(clear), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .result(res16), .carry(carry16)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .overflow(ovf16)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        cy;
    logic        ov;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic sv);
    exp_t e;
    int unsigned ai, bi, mask, full, sa, sb, sr;
    ai   = 32'(av);
    bi   = 32'(bv);
    mask = (32'd1 << w) - 32'd1;
    if (sv) begin
      full = (ai - bi) & mask;
      e.cy = (ai >= bi);
    end else begin
      full = ai + bi;
      e.cy = ((full >> w) & 32'd1) != 32'd0;
      full = full & mask;
    end
    e.res = 16'(full);
    sa = (ai >> (w - 1)) & 32'd1;
    sb = (bi >> (w - 1)) & 32'd1;
    sr = (full >> (w - 1)) & 32'd1;
    e.ov  = sv ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the 8-bit unit: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        chk("dut8 spurious done", 32'(done8), 32'd0);
      end else begin
        e = q8.pop_front();
        chk("dut8 result", 32'(res8), 32'(e.res));
        chk("dut8 carry", 32'(carry8), 32'(e.cy));
        chk("dut8 latency", 32'(cyc - e.cyc), 32'd8);
        chk("dut8 ready in done", 32'(ready8), 32'd1);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("dut8 overflow", 32'(ovf8), 32'(e.ov));
`endif
      end
    end
  end

  // Monitor for the 16-bit, 4-bits-per-cycle unit.
  always @(negedge clk) begin
    exp_t e;
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        chk("dut16 spurious done", 32'(done16), 32'd0);
      end else begin
        e = q16.pop_front();
        chk("dut16 result", 32'(res16), 32'(e.res));
        chk("dut16 carry", 32'(carry16), 32'(e.cy));
        chk("dut16 latency", 32'(cyc - e.cyc), 32'd4);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("dut16 overflow", 32'(ovf16), 32'(e.ov));
`endif
      end
    end
  end

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic sv, input bit push);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (ready8 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("dut8 ready timeout", 32'(ready8), 32'd1);
    end else begin
      start8 = 1'b1; a8 = av; b8 = bv; sub8 = sv;
      @(posedge clk);
      #1;
      if (push) begin
        e = model(8, {8'd0, av}, {8'd0, bv}, sv);
        e.cyc = cyc;
        q8.push_back(e);
      end
      chk("dut8 busy after accept", 32'(busy8), 32'd1);
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    end
  endtask

  task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic sv);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (ready16 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("dut16 ready timeout", 32'(ready16), 32'd1);
    end else begin
      start16 = 1'b1; a16 = av; b16 = bv; sub16 = sv;
      @(posedge clk);
      #1;
      e = model(16, av, bv, sv);
      e.cyc = cyc;
      q16.push_back(e);
      chk("dut16 busy after accept", 32'(busy16), 32'd1);
      @(negedge clk);
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("pending operations", 32'(q8.size() + q16.size()), 32'd0);
  endtask

  initial begin
    // Reset both units and check the cleared outputs.
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("reset ready8", 32'(ready8), 32'd1);
    chk("reset busy8", 32'(busy8), 32'd0);
    chk("reset done8", 32'(done8), 32'd0);
    chk("reset result8", 32'(res8), 32'd0);
    chk("reset carry8", 32'(carry8), 32'd0);
    chk("reset ready16", 32'(ready16), 32'd1);
    chk("reset result16", 32'(res16), 32'd0);
    @(negedge clk);
    clear = 1'b0;

    // Directed cases, issued back-to-back so each start lands in DONE.
    issue8(8'd7, 8'd3, 1'b0, 1'b1);
    issue8(8'd6, 8'd4, 1'b1, 1'b1);
    issue8(8'd4, 8'd6, 1'b1, 1'b1);
    issue8(8'd255, 8'd1, 1'b0, 1'b1);
    issue8(8'd127, 8'd1, 1'b0, 1'b1);
    issue8(8'h80, 8'h01, 1'b1, 1'b1);
    issue8(8'd0, 8'd0, 1'b0, 1'b1);
    issue8(8'd0, 8'd255, 1'b1, 1'b1);
    issue8(8'd200, 8'd200, 1'b1, 1'b1);

    // Random traffic with occasional idle gaps.
    for (int i = 0; i < 150; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 12)) @(negedge clk);
      end
    end

    // A start pulse in the middle of RUN must be ignored.
    issue8(8'h5A, 8'h33, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain();

    // Clear during RUN aborts the operation without a done pulse.
    issue8(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("abort ready8", 32'(ready8), 32'd1);
    chk("abort busy8", 32'(busy8), 32'd0);
    chk("abort done8", 32'(done8), 32'd0);
    chk("abort result8", 32'(res8), 32'd0);
    chk("abort carry8", 32'(carry8), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    repeat (12) @(negedge clk);
    issue8(8'h40, 8'h25, 1'b1, 1'b1);
    drain();

    // Wider configuration: four bits per step.
    issue16(16'h1234, 16'h0FFF, 1'b0);
    issue16(16'hFFFF, 16'h0001, 1'b0);
    issue16(16'h8000, 16'h0001, 1'b1);
    issue16(16'h7FFF, 16'h0001, 1'b0);
    for (int i = 0; i < 40; i++) begin
      issue16(16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor, the successor to the 8-bit serial adder.
- Loads two WIDTH-bit operands on a start pulse and processes BITS_PER_CYCLE bits per clock, LSB first.
- Flags completion with a done pulse and holds the result until the next operation.
- Serves as a small-area arithmetic unit for datapath labs.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥2.
BITS_PER_CYCLE, 1, bits consumed per clock; must divide WIDTH exactly (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock.
clear  input  1  synchronous active-high reset.
start  input  1  request; sampled only when ready=1.
sub  input  1  mode latched at start: 0 = a+b, 1 = a-b.
a  input  WIDTH  operand A, latched at start.
b  input  WIDTH  operand B, latched at start.
ready  output  1  1 in IDLE or DONE; start is accepted.
busy  output  1  1 in RUN.
done  output  1  one-cycle pulse when the result is valid.
result  output  WIDTH  sum/difference, held until the next accepted start.
carry  output  1  final carry-out; in subtract mode, 1 = no borrow (a ≥ b unsigned).

Behaviour:
- Reset (clear=1 at a clk edge, in any state including RUN):
  - state → IDLE.
  - result=0, carry=0, done=0, busy=0, ready=1.
  - internal shift registers, step counter and carry FF cleared.
  - clear has priority over start.
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --last step--> DONE.
  - DONE --start--> RUN.
  - DONE --no start--> IDLE.
- Accept (start=1 while ready=1):
  - Latch A_sh=a and B_sh = sub ? ~b : b.
  - Carry FF = sub; latch sub.
  - Counter = 0; result unchanged until done.
- RUN step (once per clk):
  - Low BITS_PER_CYCLE bits of A_sh/B_sh plus the carry FF go through the ripple slice.
  - Sum bits are shifted into the result shift register from the MSB end.
  - A_sh and B_sh shift right by BITS_PER_CYCLE.
  - Carry FF takes the slice carry-out; counter increments.
- Last step: when counter = WIDTH/BITS_PER_CYCLE-1, the next state is DONE.
- DONE (1 cycle):
  - done=1; result and carry outputs valid, updated from the shift register and carry FF on the DONE entry edge.
- Latency: start accepted at edge E0 → done=1 during the cycle after edge E0+WIDTH/BITS_PER_CYCLE.
  - Example: WIDTH=8, BITS_PER_CYCLE=1 gives 8 RUN cycles, then done in cycle 9.
- start while busy=1: ignored; no queuing, no error.
- start during DONE: accepted back-to-back; done still pulses that cycle and the new run starts on the next edge.
- Arithmetic: modulo 2^WIDTH.
  - Unsigned overflow on add → carry=1.
  - Borrow on sub → carry=0.
- a, b and sub may change freely after acceptance without affecting the operation.

Optional Feature:
SERIAL_ADDSUB_OVF_EN
- Defined: adds output port overflow (1 bit), the two's-complement signed overflow.
  - Computed as the XOR of the carry into and out of the MSB during the last step.
  - Valid with done; held like result; cleared by reset.
- Undefined: no overflow port and no extra logic.

Decomposition:
- Package serial_pkg:
  - state enum typedef (IDLE, RUN, DONE);
  - localparam function computing the step count and counter width ($clog2(WIDTH/BITS_PER_CYCLE) with min 1).
- Sub-module serial_fa_slice:
  - combinational BITS_PER_CYCLE-bit ripple full-adder slice;
  - inputs x, y, cin; outputs s, cout, cmsb_in (carry into the slice MSB, used for overflow).
- Top module: FSM, shift registers, counter and output registers.

Test Plan:
1. WIDTH=8, BPC=1: clear 1 cycle, then start with a=7, b=3, sub=0 → busy for 8 cycles, done in cycle 9; result=10, carry=0.
2. Sub: a=6, b=4, sub=1 → result=2, carry=1. Then a=4, b=6, sub=1 → result=254, carry=0.
3. Wrap and overflow: a=255, b=1, add → result=0, carry=1. With OVF_EN, a=127, b=1 → result=128, overflow=1, carry=0.
4. Handshake:
   - start pulsed mid-RUN → ignored, original result is produced;
   - start held during DONE → next run begins immediately, with exactly one done pulse per operation.
5. Reset mid-operation: clear asserted at RUN step 4 → next cycle IDLE, result=0, done never pulses; a fresh start then computes correctly.
6. WIDTH=16, BPC=4: a=0x1234, b=0x0FFF, add → done after 4 RUN cycles; result=0x2233, carry=0.
